// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and types for the UART command decoder.
//   - ASCII codes recognised by the decoder (framing, digits, command letters)
//   - decoder state encoding
//   - helper that folds two BCD digits into a 7-bit binary value
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_U_UC = 8'h55;
  localparam logic [7:0] ASCII_U_LC = 8'h75;
  localparam logic [7:0] ASCII_D_UC = 8'h44;
  localparam logic [7:0] ASCII_D_LC = 8'h64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIG1 = 2'd1,
    ST_DIG2 = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  // tens*10 + ones; both inputs are 0..9 so the result (max 99) fits 7 bits.
  function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] tens,
                                                 input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: first-word-fall-through RX FIFO read port.
//   rx_data  : head byte, valid whenever rx_empty = 0
//   rx_empty : FIFO empty flag
//   rx_pop   : one-cycle pop strobe, head byte consumed in the same cycle
// master = FIFO side, slave = consumer (decoder) side.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_pop;

  modport master (output rx_data, output rx_empty, input rx_pop);
  modport slave  (input rx_data, input rx_empty, output rx_pop);
endinterface

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: clear/enable up-counter with a terminal-count pulse.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (has priority over en)
//   en       : count enable
//   tc       : high while enabled, not cleared, and the count equals
//              TIMEOUT_CLKS-1
module cmd_timeout_cnt #(
  parameter int unsigned TIMEOUT_CLKS = 100_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = en && !clr && (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns bytes from an RX FIFO into control pulses.
//   clk, rst      : clock, asynchronous active-low reset
//   rx            : FIFO read port (rx_data, rx_empty, rx_pop)
//   btn_run/clear/up/down : one-cycle pulses for R/C/U/D (either case)
//   set_value     : value from "#d" or "#dd" + CR/LF, held between strobes
//   set_valid     : one-cycle strobe accompanying a new set_value
//   cmd_err       : one-cycle strobe for a rejected byte or a timeout
//   busy          : high while a '#' sequence is in progress
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 100_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_decoder_if.slave   rx,
  output logic                btn_run,
  output logic                btn_clear,
  output logic                btn_up,
  output logic                btn_down,
  output logic [6:0]          set_value,
  output logic                set_valid,
  output logic                cmd_err,
  output logic                busy
);

  state_t     state_q, state_d;
  logic       ready_q;
  logic       pop_q;
  logic       pop;
  logic [3:0] d1_q, d1_d, d0_q, d0_d;
  logic [6:0] set_value_d;
  logic       run_d, clear_d, up_d, down_d, set_valid_d, err_d;
  logic       tmo_tc;

  logic [7:0] byte_in;
  logic       is_digit;
  logic       is_eol;
  logic [3:0] digit_val;

  // ready_q holds off the first pop until one edge after reset release;
  // pop_q forces a gap cycle after every pop.
  assign pop       = ready_q && !rx.rx_empty && !pop_q;
  assign rx.rx_pop = pop;
  assign busy      = (state_q != ST_IDLE);

  assign byte_in   = rx.rx_data;
  assign is_digit  = (byte_in >= ASCII_0) && (byte_in <= ASCII_9);
  assign is_eol    = (byte_in == ASCII_CR) || (byte_in == ASCII_LF);
  assign digit_val = 4'(byte_in - ASCII_0);

  cmd_timeout_cnt #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .CNT_W        (CNT_W)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (pop || (state_q == ST_IDLE)),
    .en  (state_q != ST_IDLE),
    .tc  (tmo_tc)
  );

  // A pop takes priority over a coincident timeout.
  always_comb begin
    state_d     = state_q;
    d1_d        = d1_q;
    d0_d        = d0_q;
    set_value_d = set_value;
    run_d       = 1'b0;
    clear_d     = 1'b0;
    up_d        = 1'b0;
    down_d      = 1'b0;
    set_valid_d = 1'b0;
    err_d       = 1'b0;

    if (pop) begin
      unique case (state_q)
        ST_IDLE: begin
          case (byte_in)
            ASCII_R_UC, ASCII_R_LC: run_d   = 1'b1;
            ASCII_C_UC, ASCII_C_LC: clear_d = 1'b1;
            ASCII_U_UC, ASCII_U_LC: up_d    = 1'b1;
            ASCII_D_UC, ASCII_D_LC: down_d  = 1'b1;
            ASCII_HASH:             state_d = ST_DIG1;
            ASCII_CR, ASCII_LF:     ;
            default:                err_d   = 1'b1;
          endcase
        end
        ST_DIG1: begin
          if (is_digit) begin
            d1_d    = digit_val;
            state_d = ST_DIG2;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DIG2: begin
          if (is_digit) begin
            d0_d    = digit_val;
            state_d = ST_TERM;
          end else if (is_eol) begin
            set_value_d = {3'b000, d1_q};
            set_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_TERM: begin
          if (is_eol) begin
            set_value_d = bcd_pair_to_bin(d1_q, d0_q);
            set_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_tc) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      pop_q     <= 1'b0;
      d1_q      <= '0;
      d0_q      <= '0;
      set_value <= '0;
      btn_run   <= 1'b0;
      btn_clear <= 1'b0;
      btn_up    <= 1'b0;
      btn_down  <= 1'b0;
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      pop_q     <= pop;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      set_value <= set_value_d;
      btn_run   <= run_d;
      btn_clear <= clear_d;
      btn_up    <= up_d;
      btn_down  <= down_d;
      set_valid <= set_valid_d;
      cmd_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: FIFO model feeding bytes, event monitor,
// directed scenarios with literal expectations and a randomized run checked
// against a string-level parser model.
module tb_uart_cmd_decoder;

  localparam int TMO = 50;

  typedef struct packed {
    logic [2:0] kind;
    logic [6:0] val;
  } ev_t;

  localparam logic [2:0] EV_RUN = 3'd0, EV_CLR = 3'd1, EV_UP = 3'd2,
                         EV_DN  = 3'd3, EV_SET = 3'd4, EV_ERR = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_run, btn_clear, btn_up, btn_down, set_valid, cmd_err, busy;
  logic [6:0] set_value;

  always #5 clk = ~clk;

  uart_cmd_decoder_if rx_if ();

  uart_cmd_decoder #(.TIMEOUT_CLKS(TMO), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_if),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .set_value (set_value),
    .set_valid (set_valid),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  logic [7:0] fifo_q[$];
  ev_t        exp_q[$], obs_q[$];
  bit         busy_log[$], pop_log[$], sv_log[$], err_log[$];
  int         vectors = 0, miscompares = 0;
  int         viol_empty = 0, viol_space = 0, viol_multi = 0;
  int         viol_late = 0, viol_hold = 0;
  bit         drv_took, prev_pop, prev_rst;
  logic [6:0] prev_set_value;
  int         mon_n;
  bit         m_in_seq;
  int         m_digits[$];

  // FIFO model: a byte seen popped before an edge leaves the head after it.
  initial begin
    rx_if.rx_empty = 1'b1;
    rx_if.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      drv_took = rst && rx_if.rx_pop;
      @(posedge clk);
      #1;
      if (drv_took && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rx_if.rx_empty = (fifo_q.size() == 0);
      rx_if.rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor: records strobes as events, per-cycle logs and invariant breaks.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_if.rx_pop && rx_if.rx_empty) viol_empty++;
      if (rst) begin
        mon_n = btn_run + btn_clear + btn_up + btn_down + set_valid + cmd_err;
        if (mon_n > 1) viol_multi++;
        if (rx_if.rx_pop && prev_pop) viol_space++;
        if ((btn_run || btn_clear || btn_up || btn_down || set_valid) && !prev_pop)
          viol_late++;
        if (prev_rst && !set_valid && set_value !== prev_set_value) viol_hold++;
        if (btn_run)   obs_q.push_back({EV_RUN, 7'd0});
        if (btn_clear) obs_q.push_back({EV_CLR, 7'd0});
        if (btn_up)    obs_q.push_back({EV_UP, 7'd0});
        if (btn_down)  obs_q.push_back({EV_DN, 7'd0});
        if (set_valid) obs_q.push_back({EV_SET, set_value});
        if (cmd_err)   obs_q.push_back({EV_ERR, 7'd0});
        busy_log.push_back(busy);
        pop_log.push_back(rx_if.rx_pop);
        sv_log.push_back(set_valid);
        err_log.push_back(cmd_err);
      end
      prev_pop       = rst && rx_if.rx_pop;
      prev_rst       = rst;
      prev_set_value = set_value;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  // Reference parser: a '#' opens a sequence of up to two digits closed by
  // CR/LF; anything else inside the sequence is an error.
  function automatic void model_byte(input logic [7:0] b);
    int v;
    if (!m_in_seq) begin
      if (b == "R" || b == "r")      exp_q.push_back({EV_RUN, 7'd0});
      else if (b == "C" || b == "c") exp_q.push_back({EV_CLR, 7'd0});
      else if (b == "U" || b == "u") exp_q.push_back({EV_UP, 7'd0});
      else if (b == "D" || b == "d") exp_q.push_back({EV_DN, 7'd0});
      else if (b == "#") begin
        m_in_seq = 1'b1;
        m_digits.delete();
      end else if (b != 8'h0D && b != 8'h0A) exp_q.push_back({EV_ERR, 7'd0});
    end else if (b >= "0" && b <= "9" && m_digits.size() < 2) begin
      m_digits.push_back(int'(b) - 48);
    end else begin
      m_in_seq = 1'b0;
      if ((b == 8'h0D || b == 8'h0A) && m_digits.size() > 0) begin
        v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        exp_q.push_back({EV_SET, 7'(v)});
      end else begin
        exp_q.push_back({EV_ERR, 7'd0});
      end
    end
  endfunction

  task automatic clear_logs();
    @(posedge clk);
    #2;
    obs_q.delete(); exp_q.delete();
    busy_log.delete(); pop_log.delete(); sv_log.delete(); err_log.delete();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #2;
      if (fifo_q.size() == 0 && rx_if.rx_empty && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b0;
    fifo_q.delete();
    push("r");
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_if.rx_pop, btn_run, btn_clear, btn_up, btn_down, set_valid, cmd_err, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 00000000",
               {rx_if.rx_pop, btn_run, btn_clear, btn_up, btn_down, set_valid, cmd_err, busy});
    end
    vectors++;
    if (set_value !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_set_value got %0d want 0", set_value);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (rx_if.rx_pop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_pop got rx_pop=%b before first edge want 0", rx_if.rx_pop);
    end
    obs_q.delete();
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL reset_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== {EV_RUN, 7'd0}) begin
      miscompares++;
      $display("FAIL reset_first_cmd got %0d events want one btn_run", obs_q.size());
    end
  endtask

  task automatic test_commands();
    bit ok;
    int p[$];
    clear_logs();
    push("r"); push("C"); push("u"); push("D");
    exp_q.push_back({EV_RUN, 7'd0}); exp_q.push_back({EV_CLR, 7'd0});
    exp_q.push_back({EV_UP, 7'd0});  exp_q.push_back({EV_DN, 7'd0});
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL cmd_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL cmd_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL cmd_ev%0d got kind=%0d val=%0d want kind=%0d val=%0d",
                 i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
    foreach (pop_log[i]) if (pop_log[i]) p.push_back(i);
    vectors++;
    if (p.size() != 4) begin
      miscompares++;
      $display("FAIL cmd_pops got %0d want 4", p.size());
    end
    for (int i = 1; i < p.size(); i++) begin
      vectors++;
      if (p[i] - p[i-1] < 2) begin
        miscompares++;
        $display("FAIL cmd_pop_gap got %0d want >=2", p[i] - p[i-1]);
      end
    end
  endtask

  task automatic test_set_two_digits();
    bit ok;
    int p, s, bad;
    clear_logs();
    push("#"); push("4"); push("2"); push(8'h0D);
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL set42_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== {EV_SET, 7'd42}) begin
      miscompares++;
      $display("FAIL set42_events got %0d events (first val=%0d) want one set_value=42",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].val : 7'd0);
    end
    p = -1; s = -1; bad = 0;
    foreach (pop_log[i]) if (pop_log[i] && p < 0) p = i;
    foreach (sv_log[i])  if (sv_log[i] && s < 0) s = i;
    vectors++;
    if (p < 0 || s <= p) begin
      miscompares++;
      $display("FAIL set42_window got pop=%0d set_valid=%0d want pop before set_valid", p, s);
    end else begin
      for (int i = p + 1; i < s; i++) if (busy_log[i] !== 1'b1) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL set42_busy got %0d low cycles want 0", bad);
      end
      vectors++;
      if (busy_log[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL set42_busy_end got %b want 0", busy_log[s]);
      end
    end
  endtask

  task automatic test_set_one_digit();
    bit ok;
    clear_logs();
    push("#"); push("7"); push(8'h0A);
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL set7_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== {EV_SET, 7'd7}) begin
      miscompares++;
      $display("FAIL set7_events got %0d events (first val=%0d) want one set_value=7",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].val : 7'd0);
    end
  endtask

  task automatic test_third_digit();
    bit ok;
    clear_logs();
    push("#"); push("1"); push("2"); push("3"); push("R");
    exp_q.push_back({EV_ERR, 7'd0}); exp_q.push_back({EV_RUN, 7'd0});
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL digit3_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL digit3_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL digit3_ev%0d got kind=%0d want kind=%0d", i, obs_q[i].kind, exp_q[i].kind);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL digit3_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_bad_chars();
    bit ok;
    clear_logs();
    push("X"); push(8'h0D); push("#"); push("A"); push("#"); push(8'h0A);
    repeat (3) exp_q.push_back({EV_ERR, 7'd0});
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bad_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL bad_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bad_ev%0d got kind=%0d want kind=%0d", i, obs_q[i].kind, exp_q[i].kind);
      end
    end
  endtask

  // Responses to a popped byte show up one monitor sample after the pop;
  // the timeout strobe lands TMO clock edges after the edge consuming '5'.
  task automatic test_timeout();
    bit ok;
    int p[$];
    int e;
    clear_logs();
    push("#"); push("5");
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tmo_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== {EV_ERR, 7'd0}) begin
      miscompares++;
      $display("FAIL tmo_events got %0d events want one cmd_err", obs_q.size());
    end
    e = -1;
    foreach (pop_log[i]) if (pop_log[i]) p.push_back(i);
    foreach (err_log[i]) if (err_log[i] && e < 0) e = i;
    vectors++;
    if (p.size() != 2 || e != p[p.size()-1] + 1 + TMO) begin
      miscompares++;
      $display("FAIL tmo_latency got pops=%0d err_at=%0d want 2 pops, err at pop+%0d",
               p.size(), e, 1 + TMO);
    end else begin
      vectors++;
      if (busy_log[e] !== 1'b0) begin
        miscompares++;
        $display("FAIL tmo_busy got %b want 0", busy_log[e]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    clear_logs();
    push("#"); push("9");
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n = 0;
      foreach (pop_log[i]) if (pop_log[i]) n++;
      if (n >= 2) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_pops got %0d pops want 2", n); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({btn_run, btn_clear, btn_up, btn_down, set_valid, cmd_err, busy, set_value} !== 14'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got %b want 0",
               {btn_run, btn_clear, btn_up, btn_down, set_valid, cmd_err, busy, set_value});
    end
    rst = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL rstmid_strobes got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int r;
    logic [7:0] b;
    logic [7:0] cmd_tab [8];
    cmd_tab = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h75, 8'h55, 8'h64, 8'h44};
    m_in_seq = 1'b0;
    m_digits.delete();
    clear_logs();
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      b = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 50) b = 8'h23;
      else if (r < 65) b = r[0] ? 8'h0D : 8'h0A;
      else if (r < 88) b = cmd_tab[$urandom_range(0, 7)];
      else             b = 8'($urandom_range(0, 255));
      push(b);
      model_byte(b);
    end
    if (m_in_seq) begin
      push("X");
      model_byte("X");
    end
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rand_drain got timeout want idle"); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_ev%0d got kind=%0d val=%0d want kind=%0d val=%0d",
                 i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
  endtask

  task automatic test_invariants();
    vectors++;
    if (viol_empty != 0) begin miscompares++; $display("FAIL pop_when_empty got %0d want 0", viol_empty); end
    vectors++;
    if (viol_space != 0) begin miscompares++; $display("FAIL pop_spacing got %0d want 0", viol_space); end
    vectors++;
    if (viol_multi != 0) begin miscompares++; $display("FAIL one_hot_pulses got %0d want 0", viol_multi); end
    vectors++;
    if (viol_late != 0) begin miscompares++; $display("FAIL pulse_after_pop got %0d want 0", viol_late); end
    vectors++;
    if (viol_hold != 0) begin miscompares++; $display("FAIL set_value_hold got %0d want 0", viol_hold); end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_set_two_digits();
    test_set_one_digit();
    test_third_digit();
    test_bad_chars();
    test_timeout();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 100_000_000, the inter-character timeout in clk cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 27, the timeout counter width; CNT_W SHALL satisfy 2^CNT_W > TIMEOUT_CLKS.
REQ-003 clk  in  1  system clock; the block uses one clock, and all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 rx_data  in  8  head byte of the RX FIFO, first-word fall-through, valid whenever rx_empty=0.
REQ-006 rx_empty  in  1  RX FIFO empty flag.
REQ-007 rx_pop  out  1  one-cycle pop strobe to the RX FIFO; the byte is consumed in the same cycle.
REQ-008 btn_run  out  1  one-cycle run/stop pulse.
REQ-009 btn_clear  out  1  one-cycle clear pulse.
REQ-010 btn_up  out  1  one-cycle up pulse.
REQ-011 btn_down  out  1  one-cycle down pulse.
REQ-012 set_value  out  7  decoded numeric set value, 0..99, held until the next set_valid.
REQ-013 set_valid  out  1  one-cycle strobe; set_value is valid in the same cycle.
REQ-014 cmd_err  out  1  one-cycle error strobe.
REQ-015 busy  out  1  high while a '#' sequence is in progress (state not IDLE).

Function
REQ-016 Pop rule: the block SHALL assert rx_pop only when rx_empty=0, and SHALL sample rx_data in that cycle.
REQ-017 After any pop, rx_pop SHALL be low for at least one cycle, so at most one pop occurs per 2 cycles.
REQ-018 The block SHALL never assert rx_pop when rx_empty=1.
REQ-019 The state machine SHALL have the states IDLE, DIG1, DIG2 and TERM.
REQ-020 IDLE single-character commands, case-insensitive: 'R'/'r' -> btn_run; 'C'/'c' -> btn_clear; 'U'/'u' -> btn_up; 'D'/'d' -> btn_down.
REQ-021 Each command pulse SHALL occur in the cycle after the pop, and the state SHALL stay IDLE.
REQ-022 In IDLE, '#' (0x23) SHALL move the state to DIG1; CR (0x0D) and LF (0x0A) SHALL be ignored silently; any other byte SHALL pulse cmd_err.
REQ-023 In DIG1, a digit '0'..'9' SHALL store d1 and move to DIG2; any other byte SHALL pulse cmd_err and return to IDLE.
REQ-024 In DIG2, a digit SHALL store d0 and move to TERM.
REQ-025 In DIG2, CR or LF SHALL produce set_value=d1 with set_valid and return to IDLE.
REQ-026 In DIG2, any other byte SHALL pulse cmd_err and return to IDLE.
REQ-027 In TERM, CR or LF SHALL produce set_value=d1*10+d0 with set_valid and return to IDLE.
REQ-028 In TERM, any other byte (including a third digit) SHALL pulse cmd_err and return to IDLE.
REQ-029 Every byte that causes cmd_err SHALL be discarded and SHALL NOT be reinterpreted as a command.
REQ-030 The arithmetic d1*10+d0 SHALL be computed at 7-bit width; its maximum is 99 and it never overflows.
REQ-031 set_value SHALL update only together with set_valid.
REQ-032 Timeout counter: it SHALL be cleared on every pop and in IDLE, and SHALL increment each cycle in DIG1, DIG2 and TERM.
REQ-033 When the counter reaches TIMEOUT_CLKS-1, the block SHALL pulse cmd_err and go to IDLE.
REQ-034 If a pop and the timeout occur in the same cycle, the pop SHALL win and the counter SHALL clear.
REQ-035 Output pulses SHALL be registered, with at most one of btn_*/set_valid/cmd_err high in any cycle.

Reset
REQ-036 While rst=0: state=IDLE, counter=0, d1=d0=0, set_value=0, and all pulse outputs, rx_pop and busy = 0.
REQ-037 A reset asserted mid-sequence SHALL abandon the sequence with no set_valid or cmd_err.
REQ-038 After reset deasserts, the first pop SHALL occur no earlier than the second rising edge.

Structure
REQ-039 Package uart_cmd_pkg SHALL hold the ASCII constants ('#', CR, LF, command letters, '0', '9') and the state encoding.
REQ-040 One sub-module, cmd_timeout_cnt, SHALL be used: a clear/enable counter with a terminal-count pulse, parameterised by TIMEOUT_CLKS and CNT_W.
REQ-041 Digit detection and ASCII-to-BCD conversion SHALL be combinational logic inside the top module.

Verification
REQ-042 FIFO holds "r","C","u","D" -> btn_run, btn_clear, btn_up, btn_down each pulse once in that order; there are 4 pops, spaced >= 2 cycles apart.
REQ-043 Bytes "#","4","2",CR -> one set_valid with set_value=42; busy is high from the '#' pop until the set_valid cycle; no cmd_err.
REQ-044 Bytes "#","7",LF -> set_valid with set_value=7.
REQ-045 Bytes "#","1","2","3" -> cmd_err on '3', state=IDLE, and a following "R" pulses btn_run.
REQ-046 Run with TIMEOUT_CLKS=50: bytes "#","5" then FIFO empty -> cmd_err exactly 50 cycles after the '5' pop, then busy=0.
REQ-047 Bytes "X" -> cmd_err; reset pulse after "#","9" -> no strobe, outputs 0; rx_pop never asserted while rx_empty=1 (assertion held throughout all runs).
